// File: rtl/cdb_rr_queue_pkg.sv
// Shared machine definitions used by the CDB path, plus small helpers
// for the round-robin CDB queue.

`ifndef N
`define N 2
`endif
`ifndef NUM_FU_ALU
`define NUM_FU_ALU 2
`endif
`ifndef NUM_FU_MULT
`define NUM_FU_MULT 1
`endif
`ifndef LD_SZ
`define LD_SZ 1
`endif

package sys_defs;

  typedef struct packed {
    logic       valid;
    logic [4:0] dest_reg_idx;
  } DECODED_INST;

  typedef struct packed {
    logic [5:0] reg_idx;
  } MAP_TAG;

  typedef struct packed {
    DECODED_INST decoded_vals;
    MAP_TAG      t;
  } DECODED_PACKET;

  typedef struct packed {
    DECODED_PACKET decoded_vals;
    logic [31:0]   result;
  } FU_PACKET;

  typedef struct packed {
    logic        valid;
    logic [4:0]  reg_idx;
    logic [5:0]  p_reg_idx;
    logic [31:0] reg_val;
  } CDB_PACKET;

endpackage

package cdb_rr_queue_pkg;
  import sys_defs::*;

  // Project an FU result onto a CDB broadcast lane.
  function automatic CDB_PACKET fu_to_cdb(input FU_PACKET p);
    CDB_PACKET c;
    c.valid     = p.decoded_vals.decoded_vals.valid;
    c.reg_idx   = p.decoded_vals.decoded_vals.dest_reg_idx;
    c.p_reg_idx = p.decoded_vals.t.reg_idx;
    c.reg_val   = p.result;
    return c;
  endfunction

  // Increment modulo m.
  function automatic int wrap_inc(input int v, input int m);
    return (v + 1 >= m) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/cdb_fu_queue.sv
// Per-FU holding FIFO: circular buffer of DEPTH result packets.
// Push into a full queue and pop from an empty one are ignored.

module cdb_fu_queue import sys_defs::*; #(
  parameter int DEPTH = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  FU_PACKET                   din,
  output FU_PACKET                   head,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  FU_PACKET      mem_q [DEPTH];
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign do_pop  = pop && (cnt_q != '0);
  assign do_push = push && (cnt_q != CW'(DEPTH));
  assign head    = mem_q[rd_q];
  assign count   = cnt_q;

  // Pointer and occupancy next state; simultaneous push/pop keeps count.
  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = inc_ptr(wr_q);
    if (do_pop)  rd_d = inc_ptr(rd_q);
    if (do_push && !do_pop)      cnt_d = cnt_q + CW'(1);
    else if (!do_push && do_pop) cnt_d = cnt_q - CW'(1);
  end

  // Control state; reset and flush both empty the queue.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // Packet storage, no reset needed: validity lives in cnt_q.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/cdb_rr_queue.sv
// CDB round-robin queue: buffers FU results per FU and broadcasts up to N
// of them per cycle, rotating priority so every head is served in bounded
// time. Broadcast lanes are combinational from registered queue state.

module cdb_rr_queue import sys_defs::*, cdb_rr_queue_pkg::*; #(
  parameter int N      = `N,
  parameter int NUM_FU = `NUM_FU_ALU + `NUM_FU_MULT + `LD_SZ,
  parameter int DEPTH  = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    squash,
  input  logic [NUM_FU-1:0]       fu_done,
  input  FU_PACKET [NUM_FU-1:0]   wr_data,
  output CDB_PACKET [N-1:0]       entries,
  output logic [NUM_FU-1:0]       stall_sig
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  FU_PACKET [NUM_FU-1:0] head;
  logic [CW-1:0]         count [NUM_FU];
  logic [NUM_FU-1:0]     push, grant, nonempty;
  logic [IW-1:0]         rr_q, rr_d;

  for (genvar j = 0; j < NUM_FU; j++) begin : g_fu
    assign nonempty[j]  = (count[j] != '0);
    assign stall_sig[j] = (count[j] == CW'(DEPTH));
    assign push[j]      = fu_done[j] & ~stall_sig[j] & ~squash;

    cdb_fu_queue #(.DEPTH(DEPTH)) u_queue (
      .clock (clock),
      .reset (reset),
      .flush (squash),
      .push  (push[j]),
      .pop   (grant[j]),
      .din   (wr_data[j]),
      .head  (head[j]),
      .count (count[j])
    );
  end

  // Rotating scan from rr_q: first N non-empty heads fill lanes in order.
  always_comb begin : arb
    int won;
    int pos;
    grant   = '0;
    entries = '0;
    rr_d    = rr_q;
    won     = 0;
    pos     = 0;
    if (squash) begin
      rr_d = '0;
    end else begin
      for (int k = 0; k < NUM_FU; k++) begin
        for (int j = 0; j < NUM_FU; j++) begin
          pos = (j + NUM_FU - int'(rr_q)) % NUM_FU;
          if (pos == k && nonempty[j] && won < N) begin
            grant[j] = 1'b1;
            for (int i = 0; i < N; i++) begin
              if (i == won) entries[i] = fu_to_cdb(head[j]);
            end
            won  = won + 1;
            rr_d = IW'(wrap_inc(j, NUM_FU));
          end
        end
      end
    end
  end

  // Priority pointer register.
  always_ff @(posedge clock) begin
    if (reset) rr_q <= '0;
    else       rr_q <= rr_d;
  end

endmodule
